// File: rtl/io_stream_write_array.sv
// io_stream_write_array
// Drains an input stream into consecutive array locations starting at a
// supplied base address, then reports the number of words written on a
// completion handshake. Write-side counterpart of io_stream_read_array.
//
// Start handshake (in_*) : base address and word count, accepted only in IDLE.
// Stream input (sIn*)    : one word per fire, consumed only while running.
// Array port (arr_*)     : at most one outstanding write, request held stable
//                          until the array accepts it.
// Completion (out_*)     : out_count equals the latched word count.

module io_stream_write_array #(
    parameter int unsigned intN  = 8,
    parameter int unsigned addrN = 8
) (
    input  logic             clk,
    input  logic             rst,

    // start request
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [addrN-1:0] base,
    input  logic [addrN-1:0] len,

    // completion
    output logic             out_valid,
    input  logic             out_ready,
    output logic [addrN-1:0] out_count,

    // input stream
    input  logic [intN-1:0]  sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,

    // array write port
    output logic [addrN-1:0] arr_addr,
    output logic [intN-1:0]  arr_di,
    output logic             arr_we,
    output logic             arr_valid,
    input  logic             arr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             pend;
    logic [addrN-1:0] ptr;
    logic [addrN-1:0] rem;
    logic [addrN-1:0] count;

    logic             in_fire;
    logic             sin_fire;
    logic             arr_fire;
    logic             out_fire;

    // Handshake decode; stream readiness lets a new word replace a write
    // that the array is accepting in the same cycle.
    assign in_ready  = (state == IDLE);
    assign sIn_ready = (state == RUN) && (!pend || arr_ready);
    assign arr_valid = pend;
    assign arr_we    = pend;

    assign in_fire   = in_valid  && in_ready;
    assign sin_fire  = sIn_valid && sIn_ready;
    assign arr_fire  = pend      && arr_ready;
    assign out_fire  = out_valid && out_ready;

    // Transfer sequencer: latches the request, issues one array write per
    // accepted stream word, waits for the last write, then reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            ptr       <= '0;
            rem       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            arr_addr  <= '0;
            arr_di    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        ptr   <= base;
                        rem   <= len;
                        count <= len;
                        if (len == addrN'(0)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_count <= len;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (sin_fire) begin
                        pend     <= 1'b1;
                        arr_addr <= ptr;
                        arr_di   <= sIn;
                        ptr      <= ptr + addrN'(1);
                        rem      <= rem - addrN'(1);
                        if (rem == addrN'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (arr_fire) begin
                        pend <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (arr_fire || !pend) begin
                        pend      <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_count <= count;
                    end
                end

                DONE: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pend      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_stream_write_array.sv
// Bench for io_stream_write_array: directed scenarios plus randomized
// transfers, checked against a list model of the expected array writes
// (word i of a transfer lands at (base + i) mod 256) and timing rules.

module tb_io_stream_write_array;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] base;
    logic [7:0] len;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_count;
    logic [7:0] sIn;
    logic       sIn_valid;
    logic       sIn_ready;
    logic [7:0] arr_addr;
    logic [7:0] arr_di;
    logic       arr_we;
    logic       arr_valid;
    logic       arr_ready;

    int n_assert;
    int n_fail;
    int cyc;

    io_stream_write_array #(.intN(8), .addrN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .sIn       (sIn),
        .sIn_valid (sIn_valid),
        .sIn_ready (sIn_ready),
        .arr_addr  (arr_addr),
        .arr_di    (arr_di),
        .arr_we    (arr_we),
        .arr_valid (arr_valid),
        .arr_ready (arr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        cyc++;
    endtask

    // One complete transfer. arr_mode: 0 always ready, 1 ready 1 in 3, 2 random.
    // sin_mode: 0 stream always valid, 1 random. data_mode: 0 random, 1 ramp from data0.
    task automatic run_xfer(input logic [7:0] b, input logic [7:0] l, input int arr_mode,
                            input int sin_mode, input int data_mode, input logic [7:0] data0,
                            input int out_stall);
        logic [7:0] words[$];
        logic [7:0] exp_addr[$];
        logic [7:0] got_addr[$];
        logic [7:0] got_di[$];
        int         idx;
        int         last_fire;
        int         stall_left;
        bit         seen_done;
        bit         done;
        bit         prev_fire;
        bit         prev_stall;
        logic [7:0] pf_addr, pf_di, ps_addr, ps_di;

        for (int i = 0; i < int'(l); i++) begin
            words.push_back(data_mode != 0 ? 8'((int'(data0) + i) % 256) : 8'($urandom));
            exp_addr.push_back(8'((int'(b) + i) % 256));
        end

        nedge();
        in_valid  = 1'b1;
        base      = b;
        len       = l;
        sIn_valid = 1'b0;
        arr_ready = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        last_fire  = cyc;
        idx        = 0;
        stall_left = out_stall;
        seen_done  = 0;
        done       = 0;
        prev_fire  = 0;
        prev_stall = 0;
        pf_addr = '0; pf_di = '0; ps_addr = '0; ps_di = '0;

        for (int t = 0; t < 3000 && !done; t++) begin
            nedge();
            in_valid  = 1'($urandom_range(0, 1));
            base      = 8'($urandom);
            len       = 8'($urandom);
            sIn_valid = (sin_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            sIn       = (idx < int'(l)) ? words[idx] : 8'($urandom);
            case (arr_mode)
                0:       arr_ready = 1'b1;
                1:       arr_ready = (cyc % 3 == 0);
                default: arr_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (out_valid) begin
                out_ready = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            #1;

            chk("arr_we_eq_valid", 32'(arr_we), 32'(arr_valid));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (l == 8'd0) chk("len0_no_arr", 32'(arr_valid), 32'd0);
            if (prev_fire) begin
                chk("lat_valid", 32'(arr_valid), 32'd1);
                chk("lat_addr", 32'(arr_addr), 32'(pf_addr));
                chk("lat_di", 32'(arr_di), 32'(pf_di));
            end else if (prev_stall) begin
                chk("hold_valid", 32'(arr_valid), 32'd1);
                chk("hold_addr", 32'(arr_addr), 32'(ps_addr));
                chk("hold_di", 32'(arr_di), 32'(ps_di));
            end
            if (arr_valid && !arr_ready) chk("sin_ready_stall", 32'(sIn_ready), 32'd0);
            if (arr_mode == 0 && sin_mode == 0 && idx < int'(l))
                chk("no_bubble", 32'(sIn_ready), 32'd1);
            if (seen_done) chk("out_valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (!seen_done) begin
                    chk("done_latency", 32'(cyc), 32'(last_fire + 1));
                    seen_done = 1;
                end
                chk("out_count", 32'(out_count), 32'(l));
                chk("done_sin_ready", 32'(sIn_ready), 32'd0);
            end

            if (sIn_valid && sIn_ready) begin
                chk("sin_fire_in_range", 32'(idx < int'(l)), 32'd1);
                if (idx < int'(l)) begin
                    prev_fire = 1;
                    pf_addr   = exp_addr[idx];
                    pf_di     = words[idx];
                    idx++;
                end else begin
                    prev_fire = 0;
                end
            end else begin
                prev_fire = 0;
            end
            if (arr_valid && arr_ready) begin
                got_addr.push_back(arr_addr);
                got_di.push_back(arr_di);
                last_fire = cyc;
            end
            prev_stall = arr_valid && !arr_ready;
            ps_addr    = arr_addr;
            ps_di      = arr_di;
            if (out_valid && out_ready) done = 1;
        end

        chk("xfer_finished", 32'(done), 32'd1);
        chk("write_count", 32'(got_addr.size()), 32'(l));
        for (int i = 0; i < got_addr.size() && i < int'(l); i++) begin
            chk("write_addr", 32'(got_addr[i]), 32'(exp_addr[i]));
            chk("write_data", 32'(got_di[i]), 32'(words[i]));
        end

        nedge();
        in_valid  = 1'b0;
        sIn_valid = 1'b1;
        arr_ready = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_arr_valid", 32'(arr_valid), 32'd0);
        chk("idle_sin_ready", 32'(sIn_ready), 32'd0);
    endtask

    initial begin
        int n;
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        base      = '0;
        len       = '0;
        out_ready = 1'b0;
        sIn       = '0;
        sIn_valid = 1'b0;
        arr_ready = 1'b0;

        // reset state
        nedge();
        nedge();
        #1;
        chk("rst_arr_valid", 32'(arr_valid), 32'd0);
        chk("rst_arr_we", 32'(arr_we), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sin_ready", 32'(sIn_ready), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_arr_addr", 32'(arr_addr), 32'd0);
        chk("rst_arr_di", 32'(arr_di), 32'd0);
        nedge();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // directed scenarios
        run_xfer(8'd0,   8'd16, 0, 0, 1, 8'd0,   0);
        run_xfer(8'd0,   8'd16, 1, 0, 1, 8'd0,   0);
        run_xfer(8'd37,  8'd0,  0, 0, 0, 8'd0,   0);
        run_xfer(8'd250, 8'd10, 0, 0, 1, 8'd100, 0);
        run_xfer(8'd5,   8'd4,  0, 0, 0, 8'd0,   5);

        // reset after 5 of 16 words
        nedge();
        in_valid  = 1'b1;
        base      = 8'd0;
        len       = 8'd16;
        sIn_valid = 1'b0;
        arr_ready = 1'b1;
        #1;
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int t = 0; t < 50 && n < 5; t++) begin
            nedge();
            in_valid  = 1'b0;
            sIn_valid = 1'b1;
            sIn       = 8'(n);
            #1;
            if (sIn_valid && sIn_ready) n++;
        end
        chk("mid_words_fed", 32'(n), 32'd5);
        nedge();
        sIn_valid = 1'b0;
        arr_ready = 1'b0;
        #1;
        chk("mid_pending", 32'(arr_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_arr_valid", 32'(arr_valid), 32'd0);
        chk("mid_rst_arr_we", 32'(arr_we), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sin_ready", 32'(sIn_ready), 32'd0);
        chk("mid_rst_arr_addr", 32'(arr_addr), 32'd0);
        chk("mid_rst_arr_di", 32'(arr_di), 32'd0);
        chk("mid_rst_out_count", 32'(out_count), 32'd0);
        nedge();
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_no_done", 32'(out_valid), 32'd0);
        run_xfer(8'd8, 8'd2, 0, 0, 0, 8'd0, 0);

        // randomized transfers
        for (int k = 0; k < 8; k++) begin
            run_xfer(8'($urandom), 8'($urandom_range(0, 24)), int'($urandom_range(0, 2)),
                     1, 0, 8'd0, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
